// File: rtl/spi_cmd_scheduler_if.sv
// Request/ack and SPI_top data bundle for spi_cmd_scheduler.
// The slave side is the scheduler; the master side is the requesters plus the SPI_top readback.
interface spi_cmd_scheduler_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_word;
    logic [N_REQ-1:0]    ack;
    logic [31:0]         rd_data;
    logic [2:0]          grant_idx;
    logic                busy;
    logic [31:0]         spi_din;
    logic                spi_trigger;
    logic [31:0]         spi_dout;
    logic [15:0]         xfer_count;

    modport master (
        output req, req_word, spi_dout,
        input  ack, rd_data, grant_idx, busy, spi_din, spi_trigger, xfer_count
    );

    modport slave (
        input  req, req_word, spi_dout,
        output ack, rd_data, grant_idx, busy, spi_din, spi_trigger, xfer_count
    );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Round-robin scheduler sharing one SPI_top port between N_REQ command requesters.
// Latches the winning word, pulses trigger, waits a fixed time, captures DOUT and acks.
module spi_cmd_scheduler #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned XFER_CYCLES = 128,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input logic              clk,
    input logic              rst_n,
    spi_cmd_scheduler_if.slave bus
);

    localparam int unsigned CntMax = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWait,
        StDone,
        StGap
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        last_q;
    logic [2:0]        grant_idx_q;
    logic [N_REQ-1:0]  ack_q;
    logic [31:0]       rd_data_q;
    logic              busy_q;
    logic [31:0]       spi_din_q;
    logic              spi_trigger_q;
    logic [15:0]       xfer_count_q;

    logic              gnt_valid;
    logic [2:0]        gnt_idx;
    logic [31:0]       gnt_word;
    logic              hi_valid;
    logic              lo_valid;
    logic [2:0]        hi_idx;
    logic [2:0]        lo_idx;

    // Round-robin: first requester above last_q wins, otherwise wrap to the lowest one.
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (bus.req[j]) begin
                if (3'(j) > last_q) begin
                    if (!hi_valid) begin
                        hi_valid = 1'b1;
                        hi_idx   = 3'(j);
                    end
                end else if (!lo_valid) begin
                    lo_valid = 1'b1;
                    lo_idx   = 3'(j);
                end
            end
        end
        gnt_valid = hi_valid | lo_valid;
        gnt_idx   = hi_valid ? hi_idx : lo_idx;
        gnt_word  = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (3'(j) == gnt_idx) begin
                gnt_word = bus.req_word[32*j +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_q        <= 3'(N_REQ - 1);
            grant_idx_q   <= '0;
            ack_q         <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            spi_din_q     <= '0;
            spi_trigger_q <= 1'b0;
            xfer_count_q  <= '0;
        end else begin
            ack_q         <= '0;
            spi_trigger_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        spi_din_q     <= gnt_word;
                        grant_idx_q   <= gnt_idx;
                        spi_trigger_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= StTrig;
                    end
                end
                StTrig: begin
                    cnt_q   <= CntW'(XFER_CYCLES - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rd_data_q    <= bus.spi_dout;
                        ack_q        <= N_REQ'(1) << grant_idx_q;
                        xfer_count_q <= xfer_count_q + 16'd1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    last_q <= grant_idx_q;
                    if (GAP_CYCLES == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= CntW'(GAP_CYCLES - 1);
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.busy        = busy_q;
    assign bus.spi_din     = spi_din_q;
    assign bus.spi_trigger = spi_trigger_q;
    assign bus.xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: a two-requester instance and a single-requester
// short-transfer instance, with a scoreboard of expected grants and readback words.
module tb_spi_cmd_scheduler;

    localparam int unsigned XA = 8;
    localparam int unsigned GA = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_cmd_scheduler_if #(.N_REQ(2)) a_if ();
    spi_cmd_scheduler_if #(.N_REQ(1)) b_if ();

    spi_cmd_scheduler #(.N_REQ(2), .XFER_CYCLES(XA), .GAP_CYCLES(GA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    spi_cmd_scheduler #(.N_REQ(1), .XFER_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    // SPI_top stand-in: readback is a fixed scramble of the word on DIN.
    function automatic logic [31:0] stub(input logic [31:0] w);
        return {w[15:0], w[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign a_if.spi_dout = stub(a_if.spi_din);
    assign b_if.spi_dout = stub(b_if.spi_din);

    typedef struct {
        int          idx;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acks_a = 0;
    int   trig_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_if.ack != 0) acks_a++;
        if (a_if.spi_trigger) trig_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_ack_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_if.ack == 0 && n < 500);
        if (a_if.ack == 0) timeout("a_ack_wait");
    endtask

    task automatic wait_trig_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_if.spi_trigger && n < 500);
        if (!a_if.spi_trigger) timeout("a_trig_wait");
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_if.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (a_if.busy) timeout("a_idle_wait");
    endtask

    task automatic check_ack_a();
        exp_t e;
        if (sb.size() == 0) begin
            timeout("a_scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        chk("a_ack_vec", 32'(a_if.ack), 32'(1) << e.idx);
        chk("a_grant_idx", 32'(a_if.grant_idx), 32'(e.idx));
        chk("a_rd_data", a_if.rd_data, stub(e.word));
    endtask

    initial begin
        int   n;
        int   base;
        int   bad;
        int   acks_before;
        exp_t e;
        logic [31:0] wb;

        rst_n         = 1'b0;
        a_if.req      = '0;
        a_if.req_word = '0;
        b_if.req      = '0;
        b_if.req_word = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ack", 32'(a_if.ack), 0);
        chk("rst_rd_data", a_if.rd_data, 0);
        chk("rst_grant_idx", 32'(a_if.grant_idx), 0);
        chk("rst_busy", 32'(a_if.busy), 0);
        chk("rst_spi_din", a_if.spi_din, 0);
        chk("rst_trigger", 32'(a_if.spi_trigger), 0);
        chk("rst_xfer_count", 32'(a_if.xfer_count), 0);
        chk("rst_b_xfer_count", 32'(b_if.xfer_count), 0);

        // Basic transfer from requester 0
        rst_n         = 1'b1;
        a_if.req_word = {32'h0, 32'hABCD_0003};
        a_if.req      = 2'b01;
        base          = trig_cyc.size();
        sb.push_back('{idx: 0, word: 32'hABCD_0003});
        @(negedge clk);
        chk("basic_trigger_c1", 32'(a_if.spi_trigger), 1);
        chk("basic_din_c1", a_if.spi_din, 32'hABCD_0003);
        chk("basic_busy_c1", 32'(a_if.busy), 1);
        wait_ack_a(n);
        chk("basic_ack_latency", 32'(n), XA + 1);
        chk("basic_one_trigger", 32'(trig_cyc.size() - base), 1);
        check_ack_a();
        a_if.req = 2'b00;
        @(negedge clk);
        chk("basic_ack_one_cycle", 32'(a_if.ack), 0);
        chk("basic_xfer_count", 32'(a_if.xfer_count), 1);
        chk("basic_din_hold", a_if.spi_din, 32'hABCD_0003);
        repeat (GA) @(negedge clk);
        chk("basic_idle_busy", 32'(a_if.busy), 0);
        chk("basic_rd_hold", a_if.rd_data, stub(32'hABCD_0003));

        // Reset in WAIT: transfer aborted, priority restored to requester 0
        a_if.req_word = {32'h2222_0102, 32'h1111_0001};
        a_if.req      = 2'b11;
        @(negedge clk);
        chk("rr_after_0_grant", 32'(a_if.grant_idx), 1);
        repeat (3) @(negedge clk);
        acks_before = acks_a;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(a_if.busy), 0);
        chk("abort_din", a_if.spi_din, 0);
        chk("abort_trigger", 32'(a_if.spi_trigger), 0);
        chk("abort_grant_idx", 32'(a_if.grant_idx), 0);
        chk("abort_rd_data", a_if.rd_data, 0);
        chk("abort_xfer_count", 32'(a_if.xfer_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{idx: 0, word: 32'h1111_0001});
        sb.push_back('{idx: 1, word: 32'h2222_0102});
        @(negedge clk);
        chk("abort_regrant_trigger", 32'(a_if.spi_trigger), 1);
        chk("abort_regrant_idx", 32'(a_if.grant_idx), 0);
        wait_ack_a(n);
        check_ack_a();
        a_if.req = 2'b10;
        wait_ack_a(n);
        check_ack_a();
        a_if.req = 2'b00;
        @(negedge clk);
        chk("abort_no_ack", 32'(acks_a - acks_before), 2);
        wait_idle_a();

        // Continuous simultaneous requests alternate 0,1,0,1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        a_if.req_word = {32'h5555_0201, 32'h4444_0200};
        a_if.req      = 2'b11;
        base          = trig_cyc.size();
        for (int k = 0; k < 4; k++) begin
            e.idx  = k % 2;
            e.word = (k % 2 == 0) ? 32'h4444_0200 : 32'h5555_0201;
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            wait_ack_a(n);
            check_ack_a();
            if (k == 3) a_if.req = 2'b00;
        end
        @(negedge clk);
        wait_idle_a();
        repeat (3) @(negedge clk);
        chk("rr_trigger_count", 32'(trig_cyc.size() - base), 4);
        if (trig_cyc.size() - base == 4) begin
            for (int k = 0; k < 3; k++) begin
                chk("rr_trigger_spacing", 32'(trig_cyc[base+k+1] - trig_cyc[base+k]), XA + GA + 3);
            end
        end
        chk("rr_xfer_count", 32'(a_if.xfer_count), 4);

        // Requester 1 drops req and changes its word after grant
        a_if.req_word = {32'h7777_0302, 32'h0};
        a_if.req      = 2'b10;
        sb.push_back('{idx: 1, word: 32'h7777_0302});
        wait_trig_a();
        chk("drop_din_latched", a_if.spi_din, 32'h7777_0302);
        @(negedge clk);
        a_if.req      = 2'b00;
        a_if.req_word = {32'h9999_0000, 32'h0};
        bad = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (a_if.spi_din !== 32'h7777_0302) bad++;
        end while (a_if.ack == 0 && n < 500);
        if (a_if.ack == 0) timeout("drop_ack_wait");
        chk("drop_din_stable", 32'(bad), 0);
        check_ack_a();
        repeat (GA + 3) @(negedge clk);
        chk("drop_din_after_done", a_if.spi_din, 32'h7777_0302);
        chk("drop_rd_hold", a_if.rd_data, stub(32'h7777_0302));
        chk("drop_idle_busy", 32'(a_if.busy), 0);
        chk("drop_xfer_count", 32'(a_if.xfer_count), 5);

        // Single requester, 1-cycle transfers, no gap
        wb            = 32'hC0DE_0000;
        b_if.req_word = wb;
        b_if.req      = 1'b1;
        sb.push_back('{idx: 0, word: wb});
        for (int k = 0; k < 40; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (b_if.ack == 0 && n < 100);
            if (b_if.ack == 0) begin
                timeout("b_ack_wait");
                break;
            end
            e = sb.pop_front();
            if (k == 0) chk("b_first_latency", 32'(n), 3);
            else        chk("b_ack_period", 32'(n), 4);
            chk("b_rd_data", b_if.rd_data, stub(e.word));
            wb            = wb + 32'h0001_0001;
            b_if.req_word = wb;
            if (k == 39) b_if.req = 1'b0;
            else         sb.push_back('{idx: 0, word: wb});
        end
        repeat (4) @(negedge clk);
        chk("b_xfer_count", 32'(b_if.xfer_count), 40);
        chk("b_idle_busy", 32'(b_if.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
